// File: rtl/serial_subtractor_16_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the nibble-serial subtractor:
//   NIBBLE_W    - width of one arithmetic slice (4 bits)
//   state_t     - 2-bit controller state encoding (IDLE / RUN / DONE)
//   cnt_width() - slice counter width for a given slice count, never below 1
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-slice build still needs a 1-bit counter to keep ports legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_16_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_16_if
// Request/result bundle of the serial subtractor.
//   start      - request, honoured only while the engine is idle
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   busy       - high while slices are being processed
//   done       - one-cycle pulse when d/bout carry a new result
//   d, bout    - registered difference (mod 2^W) and final borrow
// master: the requester (controller / testbench); slave: the subtractor.
// ---------------------------------------------------------------------------
interface serial_subtractor_16_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    modport master (
        output start, a, b,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_subtractor_16_nibble_sub_bin.sv
// ---------------------------------------------------------------------------
// nibble_sub_bin
// Combinational 4-bit subtract slice with borrow-in: {bout, d} = a - b - bin.
//   a, b  in  4  operand nibbles
//   bin   in  1  borrow from the next lower slice
//   d     out 4  difference nibble
//   bout  out 1  borrow to the next higher slice
// ---------------------------------------------------------------------------
module nibble_sub_bin
    import serial_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);
    // Zero-extended subtraction: the extra MSB goes to 1 exactly when the
    // unsigned result underflows, which is the borrow out.
    logic [NIBBLE_W:0] diff;

    assign diff = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
    assign d    = diff[NIBBLE_W-1:0];
    assign bout = diff[NIBBLE_W];
endmodule

// File: rtl/serial_subtractor_16.sv
// ---------------------------------------------------------------------------
// serial_subtractor_16
// Computes d = a - b on 4*NIBBLES-bit unsigned operands, one nibble per clock,
// least significant nibble first, with a registered borrow between slices.
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset (aborts any operation)
//   bus   slave side of serial_subtractor_16_if (start/a/b in,
//         busy/done/d/bout out)
// Accept on edge t; slice k on edge t+1+k; d/bout written and done raised on
// edge t+NIBBLES; back in IDLE one cycle later.
// ---------------------------------------------------------------------------
module serial_subtractor_16
    import serial_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_16_if.slave  bus
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] K_LAST = CW'(NIBBLES - 1);

    state_t         state_reg, state_next;

    logic [W-1:0]   a_reg, b_reg;
    logic [W-1:0]   work_reg, work_next;
    logic [W-1:0]   d_reg;
    logic           bout_reg;
    logic [CW-1:0]  k_reg;
    logic           bq_reg;

    logic           accept, run, last;
    logic           busy_c, done_c;

    // ---------------- controller ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        run        = 1'b0;
        last       = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                run    = 1'b1;
                if (k_reg == K_LAST) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- slice select ----------------
    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] a_sel, b_sel;
    logic [NIBBLE_W-1:0] slice_d;
    logic                slice_bout;

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    // Compare-based mux keeps out-of-range counter values harmless when
    // NIBBLES is not a power of two.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_reg == CW'(i)) begin
                a_sel = a_nib[i];
                b_sel = b_nib[i];
            end
        end
    end

    nibble_sub_bin u_slice (
        .a    (a_sel),
        .b    (b_sel),
        .bin  (bq_reg),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Working result with the current slice already merged in, so the final
    // edge can copy a complete word straight into d_reg.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_work
            assign work_next[gi*NIBBLE_W +: NIBBLE_W] =
                (k_reg == CW'(gi)) ? slice_d : work_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            work_reg <= '0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
            k_reg    <= '0;
            bq_reg   <= 1'b0;
        end else if (accept) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            work_reg <= '0;
            k_reg    <= '0;
            bq_reg   <= 1'b0;
        end else if (run) begin
            work_reg <= work_next;
            bq_reg   <= slice_bout;
            k_reg    <= k_reg + CW'(1);
            // Outputs only move here, so partial results never show.
            if (last) begin
                d_reg    <= work_next;
                bout_reg <= slice_bout;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.d    = d_reg;
    assign bus.bout = bout_reg;

endmodule
